// File: rtl/demultiplexor_cifras.sv
// demultiplexor_cifras: rebuilds the four digit values from a time-multiplexed display bus,
// accepting each bus pattern only after it has held steady for STABLE_CYCLES edges.
module demultiplexor_cifras #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic [3:0] i_Habs,
  input  logic [3:0] i_Cifra,
  input  logic       i_Clear_error,
  output logic [3:0] o_Datos1,
  output logic [3:0] o_Datos2,
  output logic [3:0] o_Datos3,
  output logic [3:0] o_Datos4,
  output logic       o_Frame_valid,
  output logic       o_Frame_strobe,
  output logic       o_Error
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int IW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 2);

  logic [7:0]      s_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            acc_q, acc_d;
  logic [3:0]      mask_q, mask_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [3:0][3:0] datos_q, datos_d;
  logic            valid_q, valid_d;
  logic            strobe_q, strobe_d;
  logic            err_q, err_d;
  logic            match, accept, legal, blank, cap, complete, timeout;
  logic [3:0]      sel, new_mask;

  always_comb begin
    match    = {i_Habs, i_Cifra} == s_q;
    accept   = match && cnt_q == CNT_MAX && !acc_q;
    sel      = ~s_q[7:4];
    blank    = sel == 4'd0;
    // exactly one low enable: a single bit set in the inverted pattern
    legal    = !blank && (sel & (sel - 4'd1)) == 4'd0;
    cap      = accept && legal;
    new_mask = mask_q | sel;
    complete = cap && &new_mask;
    timeout  = !cap && idle_q == IDLE_LAST;
    cnt_d    = !match ? '0 : cnt_q == CNT_MAX ? cnt_q : cnt_q + CW'(1);
    acc_d    = match && (acc_q || accept);
    idle_d   = cap ? '0 : idle_q == IDLE_MAX ? idle_q : idle_q + IW'(1);
    mask_d   = (timeout || complete) ? 4'd0 : cap ? new_mask : mask_q;
    valid_d  = complete || (valid_q && !timeout);
    strobe_d = complete;
    err_d    = (accept && !legal && !blank) || (err_q && !i_Clear_error);
    datos_d  = datos_q;
    for (int k = 0; k < 4; k++)
      datos_d[k] = (cap && sel[k]) ? s_q[3:0] : datos_q[k];
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      s_q      <= 8'hF0;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      mask_q   <= 4'd0;
      idle_q   <= '0;
      datos_q  <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s_q      <= {i_Habs, i_Cifra};
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mask_q   <= mask_d;
      idle_q   <= idle_d;
      datos_q  <= datos_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  assign o_Datos1       = datos_q[0];
  assign o_Datos2       = datos_q[1];
  assign o_Datos3       = datos_q[2];
  assign o_Datos4       = datos_q[3];
  assign o_Frame_valid  = valid_q;
  assign o_Frame_strobe = strobe_q;
  assign o_Error        = err_q;
endmodule

// File: tb/tb_demultiplexor_cifras.sv
// tb_demultiplexor_cifras: directed scenarios with hand-computed expectations for the digit demultiplexer.
module tb_demultiplexor_cifras;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] habs = 4'hF;
  logic [3:0] cifra = 4'h0;
  logic       clr = 1'b0;
  logic [3:0] d1, d2, d3, d4;
  logic       valid, strobe, err;
  int checks = 0;
  int failures = 0;
  int strobes = 0;

  demultiplexor_cifras dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Habs(habs), .i_Cifra(cifra),
    .i_Clear_error(clr), .o_Datos1(d1), .o_Datos2(d2), .o_Datos3(d3),
    .o_Datos4(d4), .o_Frame_valid(valid), .o_Frame_strobe(strobe), .o_Error(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (strobe === 1'b1) strobes++;

  task automatic hold(input logic [3:0] h, input logic [3:0] c, input int n);
    habs = h;
    cifra = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({d1, d2, d3, d4} !== 16'h0000) begin
      failures++; $display("FAIL reset_data got=%h exp=0000", {d1, d2, d3, d4});
    end
    checks++;
    if ({valid, strobe, err} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {valid, strobe, err});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_scan;
    int s0;
    hold(4'b1110, 4'd3, 4);
    checks++;
    if (d1 !== 4'd0) begin failures++; $display("FAIL scan_early got=%h exp=0", d1); end
    hold(4'b1110, 4'd3, 1);
    checks++;
    if (d1 !== 4'd3) begin failures++; $display("FAIL scan_latency got=%h exp=3", d1); end
    hold(4'b1110, 4'd3, 5);
    hold(4'b1101, 4'd7, 10);
    hold(4'b1011, 4'd9, 10);
    s0 = strobes;
    for (int k = 1; k <= 10; k++) begin
      hold(4'b0111, 4'd2, 1);
      checks++;
      if (strobe !== (k == 5)) begin
        failures++; $display("FAIL scan_strobe_edge%0d got=%b exp=%b", k, strobe, k == 5);
      end
    end
    checks++;
    if (strobes - s0 !== 1) begin failures++; $display("FAIL scan_strobe_count got=%0d exp=1", strobes - s0); end
    checks++;
    if ({d1, d2, d3, d4} !== 16'h3792) begin
      failures++; $display("FAIL scan_data got=%h exp=3792", {d1, d2, d3, d4});
    end
    checks++;
    if (valid !== 1'b1) begin failures++; $display("FAIL scan_valid got=%b exp=1", valid); end
  endtask

  task automatic test_glitch;
    hold(4'b1110, 4'd5, 3);
    checks++;
    if (d1 !== 4'd3) begin failures++; $display("FAIL glitch_short got=%h exp=3", d1); end
    for (int k = 1; k <= 10; k++) begin
      hold(4'b1110, 4'd6, 1);
      checks++;
      if (d1 === 4'd5) begin failures++; $display("FAIL glitch_seen_edge%0d got=%h exp=not5", k, d1); end
    end
    checks++;
    if (d1 !== 4'd6) begin failures++; $display("FAIL glitch_final got=%h exp=6", d1); end
  endtask

  task automatic test_error;
    hold(4'b1100, 4'd4, 4);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_early got=%b exp=0", err); end
    hold(4'b1100, 4'd4, 1);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err); end
    hold(4'b1100, 4'd4, 5);
    checks++;
    if ({d1, d2, d3, d4} !== 16'h6792) begin
      failures++; $display("FAIL err_data got=%h exp=6792", {d1, d2, d3, d4});
    end
    clr = 1'b1;
    hold(4'b1100, 4'd4, 1);
    clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err); end
    hold(4'b1001, 4'd4, 4);
    clr = 1'b1;
    hold(4'b1001, 4'd4, 1);
    clr = 1'b0;
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_set_wins got=%b exp=1", err); end
    clr = 1'b1;
    hold(4'b1001, 4'd4, 1);
    clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_reclear got=%b exp=0", err); end
  endtask

  task automatic test_timeout;
    hold(4'b1110, 4'hA, 6);
    hold(4'b1101, 4'hB, 6);
    hold(4'b1011, 4'hC, 6);
    hold(4'b0111, 4'hD, 6);
    checks++;
    if (valid !== 1'b1) begin failures++; $display("FAIL to_frame got=%b exp=1", valid); end
    hold(4'b1111, 4'h0, 1021);
    checks++;
    if (valid !== 1'b1) begin failures++; $display("FAIL to_early got=%b exp=1", valid); end
    hold(4'b1111, 4'h0, 1);
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL to_fall got=%b exp=0", valid); end
    checks++;
    if ({d1, d2, d3, d4} !== 16'hABCD) begin
      failures++; $display("FAIL to_data got=%h exp=abcd", {d1, d2, d3, d4});
    end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL to_err got=%b exp=0", err); end
  endtask

  task automatic test_overwrite;
    int s0;
    s0 = strobes;
    hold(4'b1110, 4'd1, 6);
    hold(4'b1110, 4'd8, 6);
    hold(4'b1101, 4'd2, 6);
    hold(4'b1011, 4'd3, 6);
    checks++;
    if (strobes - s0 !== 0 || valid !== 1'b0) begin
      failures++; $display("FAIL ow_partial got=strobes%0d/valid%b exp=0/0", strobes - s0, valid);
    end
    checks++;
    if (d1 !== 4'd8) begin failures++; $display("FAIL ow_data1 got=%h exp=8", d1); end
    hold(4'b0111, 4'd4, 6);
    checks++;
    if (strobes - s0 !== 1 || valid !== 1'b1) begin
      failures++; $display("FAIL ow_complete got=strobes%0d/valid%b exp=1/1", strobes - s0, valid);
    end
    checks++;
    if ({d1, d2, d3, d4} !== 16'h8234) begin
      failures++; $display("FAIL ow_data got=%h exp=8234", {d1, d2, d3, d4});
    end
  endtask

  task automatic test_reset_mid;
    hold(4'b1110, 4'd7, 2);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({d1, d2, d3, d4, valid, strobe, err} !== 19'd0) begin
      failures++; $display("FAIL mid_reset got=%h exp=0", {d1, d2, d3, d4, valid, strobe, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    hold(4'b1110, 4'd1, 6);
    hold(4'b1101, 4'd2, 6);
    hold(4'b1011, 4'd3, 6);
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL mid_partial got=%b exp=0", valid); end
    hold(4'b0111, 4'd4, 6);
    checks++;
    if (valid !== 1'b1 || {d1, d2, d3, d4} !== 16'h1234) begin
      failures++; $display("FAIL mid_rescan got=%b/%h exp=1/1234", valid, {d1, d2, d3, d4});
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_glitch;
    test_error;
    test_timeout;
    test_overwrite;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/demultiplexor_cifras.md
# demultiplexor_cifras

Receive-side counterpart of the display digit multiplexer. It observes the time-multiplexed display bus (four active-low digit enables plus one shared 4-bit digit value) and rebuilds the four digit values into parallel registers. Each bus pattern must pass a stability filter before it is accepted. The block also flags malformed enable patterns and reports frame completeness, so the controller can be self-checked in system or read back by a test harness.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive clock edges a bus pattern must hold before it is accepted; legal range is 2 or more.
- TIMEOUT_CYCLES, 1024: clock cycles without an accepted capture before the frame is declared stale; legal range is 2 or more.

Ports:
- i_Clk  in  1  system clock; everything is on the rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Habs  in  4  digit enables, active-low. 1110 selects digit 1, 1101 digit 2, 1011 digit 3, 0111 digit 4.
- i_Cifra  in  4  digit value currently driven on the bus.
- i_Clear_error  in  1  synchronous clear of o_Error.
- o_Datos1..o_Datos4  out  4 each  captured digit values.
- o_Frame_valid  out  1  high when all four digits have been captured and no timeout has occurred since.
- o_Frame_strobe  out  1  one-cycle pulse each time a frame completes.
- o_Error  out  1  sticky flag for an illegal enable pattern.

## Operation
- Sample register: s_Habs/s_Cifra is loaded from the inputs on every edge. Reset value is 1111/0000.
- Stability counter cnt:
  - cnt goes to 0 on any edge where {i_Habs,i_Cifra} differs from s.
  - Otherwise cnt increments, saturating at STABLE_CYCLES-1.
- Accept event: occurs on an edge where cnt == STABLE_CYCLES-1, the input equals s, and the accepted flag is clear. The edge sets the accepted flag. The flag clears whenever cnt goes to 0, so each stable run is accepted exactly once.
- Decode at the accept event:
  - Legal one-cold pattern: write s_Cifra to the matching o_DatosN and set bit N of the seen mask.
  - 1111 (blanking): no action, no error.
  - Any other pattern (two or more lows): set o_Error. Data and mask are unchanged.
- Capturing a slot that is already marked in the mask overwrites its data; the mask is unchanged.
- Frame completion: when a capture makes the mask 1111, then on that same edge:
  - the mask clears to 0000,
  - o_Frame_strobe is 1 for the following cycle,
  - o_Frame_valid is set to 1.
- Timeout:
  - A saturating idle counter is cleared by every legal capture and increments otherwise.
  - On the edge it reaches TIMEOUT_CYCLES-1 with no capture: o_Frame_valid goes to 0 and the mask goes to 0000. Data registers hold.
- Error clear: i_Clear_error clears o_Error. If an error is set on the same edge, the set wins.
- Reset: asserting i_Reset_n low, including in mid-operation, immediately forces every output, the mask, all counters and the accepted flag to 0, and the sample register to 1111/0000.

## Timing
- Input stable from first sampling edge E0: capture is visible on o_DatosN after edge E0+STABLE_CYCLES. With the default, that is 4 edges.
- Glitch rejection: a pattern held for fewer than STABLE_CYCLES edges is never accepted.
- o_Frame_strobe and o_Frame_valid update on the same edge as the completing capture.
- o_Error asserts on the accept edge of the illegal pattern.
- No combinational path from inputs to outputs; all outputs are registered.
- Minimum scan dwell the source controller must provide per digit: STABLE_CYCLES+1 clock cycles.

## Test plan
- Reset, then scan 1110/3, 1101/7, 1011/9, 0111/2, each held 10 cycles -> o_Datos = 3,7,9,2. o_Frame_strobe pulses exactly once, 4 edges after 0111 is first sampled. o_Frame_valid=1.
- Hold 1110/5 for 3 cycles, then 1110/6 for 10 cycles -> o_Datos1=6. Value 5 is never visible.
- Drive 1100/4 for 10 cycles -> o_Error=1 and data unchanged. Pulse i_Clear_error -> o_Error=0. Clear and set on the same edge -> o_Error stays 1.
- Complete a frame, then hold 1111 for TIMEOUT_CYCLES cycles -> o_Frame_valid falls exactly TIMEOUT_CYCLES-1 edges after the last capture. Data holds. No error.
- Capture 1110/1, 1110/8, 1101/2, 1011/3 -> no strobe yet and o_Datos1=8. Then 0111/4 -> strobe occurs.
- Assert i_Reset_n low in the middle of a dwell -> all outputs are 0 at once. After release, a full scan is needed before o_Frame_valid rises.
